// File: rtl/psum_requant.sv
// psum_requant: accumulates 2x2 MAC partial-sum tiles over NumCh passes,
// then adds bias, applies a rounding arithmetic right-shift, optional ReLU
// and int8 saturation, and emits one packed int8 word per tile.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for iStart; beats are ignored
//   ACC   | adding one partial-sum beat per vld_mac until NumCh beats seen
//   RND   | bias add plus half-LSB rounding term, registered into sk
//   SAT   | shift, ReLU, clamp to int8, register oData, pulse oVld
module psum_requant #(
   parameter int IN_W   = 20,
   parameter int ACC_W  = 28,
   parameter int CNT_W  = 8,
   parameter int BIAS_W = 16
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     iStart,
   input  logic [CNT_W-1:0]         iNumCh,
   input  logic signed [BIAS_W-1:0] iBias,
   input  logic [4:0]               iShift,
   input  logic                     iReluEn,
   input  logic                     vld_mac,
   input  logic signed [IN_W-1:0]   iAcc0,
   input  logic signed [IN_W-1:0]   iAcc1,
   input  logic signed [IN_W-1:0]   iAcc2,
   input  logic signed [IN_W-1:0]   iAcc3,
   output logic                     oBusy,
   output logic                     oVld,
   output logic [31:0]              oData
);

   // Post-bias values are carried one bit wider than the accumulator.
   localparam int SW = ACC_W + 1;
   localparam logic signed [SW-1:0] Q_MAX = SW'(127);
   localparam logic signed [SW-1:0] Q_MIN = SW'(-128);

   typedef enum logic [1:0] {IDLE, ACC, RND, SAT} state_t;

   state_t                    state, stateNxt;
   logic [CNT_W-1:0]          numCh;
   logic [CNT_W-1:0]          cnt;
   logic signed [BIAS_W-1:0]  bias;
   logic [4:0]                shift;
   logic                      reluEn;
   logic signed [IN_W-1:0]    inAcc [4];
   logic signed [ACC_W-1:0]   acc   [4];
   logic signed [SW-1:0]      sk    [4];
   logic signed [SW-1:0]      shd   [4];
   logic [7:0]                q     [4];
   logic signed [SW-1:0]      rndTerm;
   logic                      startTile;
   logic                      lastBeat;

   assign inAcc[0] = iAcc0;
   assign inAcc[1] = iAcc1;
   assign inAcc[2] = iAcc2;
   assign inAcc[3] = iAcc3;

   assign startTile = (state == IDLE) && iStart;
   assign lastBeat  = (state == ACC) && vld_mac && ((cnt + CNT_W'(1)) == numCh);

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= stateNxt;
   end

   // Next-state logic and busy flag.
   always_comb begin
      stateNxt = state;
      oBusy    = 1'b0;
      case (state)
         IDLE: if (iStart) stateNxt = ACC;
         ACC: begin
            oBusy = 1'b1;
            if (lastBeat) stateNxt = RND;
         end
         RND: begin
            oBusy    = 1'b1;
            stateNxt = SAT;
         end
         SAT: begin
            oBusy    = 1'b1;
            stateNxt = IDLE;
         end
         default: stateNxt = IDLE;
      endcase
   end

   // Tile configuration is captured only when a tile starts from IDLE.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         numCh  <= '0;
         bias   <= '0;
         shift  <= '0;
         reluEn <= 1'b0;
      end else if (startTile) begin
         numCh  <= (iNumCh == '0) ? CNT_W'(1) : iNumCh;
         bias   <= iBias;
         shift  <= iShift;
         reluEn <= iReluEn;
      end
   end

   // Accumulators and pass counter; a beat coincident with iStart is dropped.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
         for (int k = 0; k < 4; k++) acc[k] <= '0;
      end else if (startTile) begin
         cnt <= '0;
         for (int k = 0; k < 4; k++) acc[k] <= '0;
      end else if (state == ACC && vld_mac) begin
         cnt <= cnt + CNT_W'(1);
         for (int k = 0; k < 4; k++) acc[k] <= acc[k] + ACC_W'(inAcc[k]);
      end
   end

   // Half-LSB rounding term. Shifts whose half-LSB cannot be represented as a
   // positive value in SW bits get no rounding; those shifts reduce any value
   // to its sign anyway.
   always_comb begin
      rndTerm = '0;
      if (shift != 5'd0 && int'(shift) <= ACC_W)
         rndTerm = SW'(1) << (shift - 5'd1);
   end

   // Bias and rounding add, one cycle in RND.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < 4; k++) sk[k] <= '0;
      end else if (state == RND) begin
         for (int k = 0; k < 4; k++) sk[k] <= SW'(acc[k]) + SW'(bias) + rndTerm;
      end
   end

   // Shift, ReLU and int8 saturation against the full-width shifted value.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         shd[k] = sk[k] >>> shift;
         q[k]   = shd[k][7:0];
         if (reluEn && shd[k] < 0)  q[k] = 8'h00;
         else if (shd[k] > Q_MAX)   q[k] = 8'h7F;
         else if (shd[k] < Q_MIN)   q[k] = 8'h80;
      end
   end

   // Output word register and single-cycle valid pulse.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         oVld  <= 1'b0;
         oData <= '0;
      end else begin
         oVld <= (state == SAT);
         if (state == SAT) oData <= {q[3], q[2], q[1], q[0]};
      end
   end

endmodule

// File: tb/tb_psum_requant.sv
// Directed bench for psum_requant: hand-computed int8 tiles, exact output
// latency, reset mid-tile, ignored beats/starts and extreme values.
module tb_psum_requant;

   logic               clk;
   logic               rstn;
   logic               iStart;
   logic [7:0]         iNumCh;
   logic signed [15:0] iBias;
   logic [4:0]         iShift;
   logic               iReluEn;
   logic               vld_mac;
   logic signed [19:0] iAcc0, iAcc1, iAcc2, iAcc3;
   logic               oBusy;
   logic               oVld;
   logic [31:0]        oData;

   int checks = 0;
   int errors = 0;

   psum_requant dut (
      .clk     (clk),
      .rstn    (rstn),
      .iStart  (iStart),
      .iNumCh  (iNumCh),
      .iBias   (iBias),
      .iShift  (iShift),
      .iReluEn (iReluEn),
      .vld_mac (vld_mac),
      .iAcc0   (iAcc0),
      .iAcc1   (iAcc1),
      .iAcc2   (iAcc2),
      .iAcc3   (iAcc3),
      .oBusy   (oBusy),
      .oVld    (oVld),
      .oData   (oData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic startTile(input logic [7:0] n, input logic signed [15:0] b,
                            input logic [4:0] s, input logic r);
      @(negedge clk);
      iStart = 1'b1; iNumCh = n; iBias = b; iShift = s; iReluEn = r;
      @(negedge clk);
      iStart = 1'b0;
   endtask

   task automatic beat(input logic signed [19:0] a0, input logic signed [19:0] a1,
                       input logic signed [19:0] a2, input logic signed [19:0] a3);
      @(negedge clk);
      vld_mac = 1'b1; iAcc0 = a0; iAcc1 = a1; iAcc2 = a2; iAcc3 = a3;
      @(negedge clk);
      vld_mac = 1'b0;
   endtask

   // Called right after the final beat (negedge after edge N). Optionally
   // drives a stray beat into the RND cycle.
   task automatic waitResult(input string tag, input logic [31:0] exp, input bit junk);
      if (junk) begin
         vld_mac = 1'b1; iAcc0 = 20'sd1000; iAcc1 = 20'sd1000; iAcc2 = 20'sd1000; iAcc3 = 20'sd1000;
      end
      @(posedge clk); #1;
      chk({tag, " oVld at N+1"}, {31'd0, oVld}, 32'd0);
      if (junk) begin
         @(negedge clk);
         vld_mac = 1'b0;
      end
      @(posedge clk); #1;
      chk({tag, " oVld at N+2"}, {31'd0, oVld}, 32'd1);
      chk({tag, " oData"}, oData, exp);
   endtask

   initial begin
      logic sawVld;
      rstn = 1'b0; iStart = 1'b0; iNumCh = '0; iBias = '0; iShift = '0; iReluEn = 1'b0;
      vld_mac = 1'b0; iAcc0 = '0; iAcc1 = '0; iAcc2 = '0; iAcc3 = '0;
      repeat (2) @(negedge clk);
      chk("reset oBusy", {31'd0, oBusy}, 32'd0);
      chk("reset oVld", {31'd0, oVld}, 32'd0);
      chk("reset oData", oData, 32'd0);
      rstn = 1'b1;

      // Single pass with saturation in both directions.
      startTile(8'd1, 16'sd0, 5'd0, 1'b0);
      chk("single busy", {31'd0, oBusy}, 32'd1);
      beat(20'sd10, -20'sd10, 20'sd300, -20'sd300);
      waitResult("single", 32'h807F_F60A, 1'b0);
      @(posedge clk); #1;
      chk("single pulse width", {31'd0, oVld}, 32'd0);
      chk("single idle busy", {31'd0, oBusy}, 32'd0);
      chk("single hold", oData, 32'h807F_F60A);

      // Reset in the middle of an accumulation discards the tile.
      startTile(8'd4, 16'sd0, 5'd0, 1'b0);
      beat(20'sd1, 20'sd1, 20'sd1, 20'sd1);
      beat(20'sd1, 20'sd1, 20'sd1, 20'sd1);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("midreset oBusy", {31'd0, oBusy}, 32'd0);
      chk("midreset oData", oData, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      sawVld = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         sawVld = sawVld | oVld;
      end
      chk("midreset no oVld", {31'd0, sawVld}, 32'd0);
      startTile(8'd1, 16'sd0, 5'd0, 1'b0);
      beat(20'sd5, 20'sd5, 20'sd5, 20'sd5);
      waitResult("post reset", 32'h0505_0505, 1'b0);

      // Three passes with bias and rounding shift; ReLU tile starts back-to-back.
      startTile(8'd3, -16'sd44, 5'd4, 1'b0);
      repeat (3) beat(20'sd100, -20'sd100, 20'sd0, 20'sd50);
      waitResult("round", 32'h07FD_EB10, 1'b0);
      startTile(8'd3, -16'sd44, 5'd4, 1'b1);
      chk("b2b pulse width", {31'd0, oVld}, 32'd0);
      chk("b2b busy", {31'd0, oBusy}, 32'd1);
      repeat (3) beat(20'sd100, -20'sd100, 20'sd0, 20'sd50);
      waitResult("relu", 32'h0700_0010, 1'b0);

      // NumCh=0 behaves as one pass; a beat coincident with iStart is dropped.
      @(negedge clk);
      iStart = 1'b1; iNumCh = 8'd0; iBias = 16'sd0; iShift = 5'd0; iReluEn = 1'b0;
      vld_mac = 1'b1; iAcc0 = 20'sd50; iAcc1 = 20'sd50; iAcc2 = 20'sd50; iAcc3 = 20'sd50;
      @(negedge clk);
      iStart = 1'b0; vld_mac = 1'b0;
      beat(20'sd7, 20'sd0, 20'sd0, 20'sd0);
      waitResult("numch0", 32'h0000_0007, 1'b0);

      // Stray beat in IDLE, gapped beats, iStart while busy, stray beat in RND.
      @(negedge clk);
      vld_mac = 1'b1; iAcc0 = 20'sd99; iAcc1 = 20'sd99; iAcc2 = 20'sd99; iAcc3 = 20'sd99;
      @(negedge clk);
      vld_mac = 1'b0;
      chk("idle beat busy", {31'd0, oBusy}, 32'd0);
      startTile(8'd2, 16'sd0, 5'd0, 1'b0);
      beat(20'sd20, -20'sd5, 20'sd1000, 20'sd3);
      @(negedge clk);
      iStart = 1'b1; iNumCh = 8'd1; iBias = 16'sd100; iShift = 5'd3; iReluEn = 1'b1;
      @(negedge clk);
      iStart = 1'b0;
      repeat (3) @(negedge clk);
      chk("gap busy", {31'd0, oBusy}, 32'd1);
      chk("gap no oVld", {31'd0, oVld}, 32'd0);
      beat(20'sd1, -20'sd5, -20'sd900, 20'sd3);
      waitResult("gapped", 32'h0664_F615, 1'b1);

      // Extremes: 255 passes of the most negative partial sum.
      startTile(8'd255, -16'sd32768, 5'd0, 1'b0);
      for (int i = 0; i < 255; i++) beat(20'sh80000, 20'sh80000, 20'sh80000, 20'sh80000);
      waitResult("extreme sh0", 32'h8080_8080, 1'b0);
      startTile(8'd255, -16'sd32768, 5'd31, 1'b0);
      for (int i = 0; i < 255; i++) beat(20'sh80000, 20'sh80000, 20'sh80000, 20'sh80000);
      waitResult("extreme sh31", 32'hFFFF_FFFF, 1'b0);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/psum_requant.md
Name: psum_requant

Overview:
- Sits directly downstream of the 3x3 MAC array.
- Consumes its four 20-bit signed partial sums (one 2x2 output tile) per valid beat and accumulates them across NUM_CH input-channel passes.
- After the last pass: adds a per-output-channel bias, applies rounding arithmetic right-shift, optional ReLU and int8 saturation.
- Emits one 32-bit packed int8 word per tile toward the output buffer.

Parameters:
- IN_W, 20, width of each signed MAC partial sum.
- ACC_W, 28, signed accumulator width (covers 256 passes of IN_W without overflow).
- CNT_W, 8, width of the pass-count configuration.
- BIAS_W, 16, signed bias width.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- iStart  in  1  one-cycle pulse: latch config, clear accumulators, begin a tile
- iNumCh  in  CNT_W  number of MAC beats to accumulate for this tile (0 treated as 1)
- iBias  in  BIAS_W  signed bias, added before shift
- iShift  in  5  right-shift amount (0..31)
- iReluEn  in  1  1 = clamp negatives to 0
- vld_mac  in  1  MAC output valid
- iAcc0..iAcc3  in  IN_W each  signed partial sums from MAC
- oBusy  out  1  tile in progress
- oVld  out  1  one-cycle pulse: oData valid
- oData  out  32  {q3,q2,q1,q0}, each int8, q0 in [7:0]

Behaviour:
- Reset (async, rstn=0): state=IDLE; oBusy=0, oVld=0, oData=0; accumulators, pass counter and latched config cleared. Reset mid-tile discards the tile; no oVld is produced.
- States:
  - IDLE: on iStart, latch iNumCh (0→1), iBias, iShift, iReluEn; clear acc0..3 and cnt; go to ACC. vld_mac in IDLE is ignored.
  - ACC: each cycle with vld_mac, acck <= acck + sext(iAcck) and cnt <= cnt+1. When the beat makes cnt+1 == NumCh, go to RND.
  - RND: one cycle; sk = acck + sext(Bias) computed in ACC_W+1 bits; if Shift>0, add 1<<(Shift-1) (round half up).
  - SAT: one cycle; arithmetic shift right by Shift; if ReluEn and negative → 0; saturate to [-128,127]; register oData; pulse oVld; go to IDLE.
- oBusy=1 in ACC, RND and SAT.
- Latency: the final vld_mac beat is sampled at edge N; oVld=1 during the cycle after edge N+2.
- iStart while oBusy=1: ignored, config unchanged.
- iStart and vld_mac in the same cycle in IDLE: the beat is NOT accumulated; the tile starts empty.
- vld_mac in RND or SAT: ignored. The producer must not issue beats past NumCh.
- Back-to-back tiles: iStart may be asserted in the same cycle as oVld (state already IDLE in that cycle); the new tile starts normally.
- Arithmetic is two's-complement throughout. Rounding add and shift must not overflow in ACC_W+1 bits. Saturation compares against the full-width shifted value.
- oData holds its value until the next oVld; oVld is never asserted for more than one cycle.

Test Plan:
- Reset mid-ACC: start NumCh=4, 2 beats, then pulse rstn low → oBusy=0, oData=0, no oVld; a following tile with NumCh=1, iAcc all 5, bias 0, shift 0 → oData=0x05050505.
- Single pass: NumCh=1, iAcc0..3 = 10, -10, 300, -300; bias 0; shift 0; ReluEn 0 → oData={0x80,0x7F,0xF6,0x0A}, oVld exactly 2 cycles after the beat.
- Multi-pass with rounding: NumCh=3, each beat iAcc0=100 (sum 300), bias=-44, shift=4 → (256+8)>>4=16 → q0=0x10; iAcc1=-100 each (sum -300) → (-344+8)>>4=-21 → q1=0xEB.
- ReLU: same as above with ReluEn=1 → q1=0x00, q0=0x10.
- Gapped valids and NumCh=0: NumCh=0 with one beat iAcc0=7 → q0=0x07. NumCh=2 with beats separated by 5 idle cycles → correct sum; vld_mac during IDLE/RND ignored; iStart while busy leaves config unchanged.
- Extremes: NumCh=255, every iAcc = -524288, bias=-32768, shift=0 → all lanes 0x80; with shift=31 → all lanes 0xFF (-1); no internal overflow.
